// File: rtl/ap_job_ctrl.sv
// ap_job_ctrl: job sequencer driving the associative processor (AP).
// Optional RUN watchdog enabled by defining AP_CTRL_TIMEOUT_EN.
module ap_job_ctrl #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DATA_W         = 8,
    parameter logic        RES_COL        = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [2:0]        job_cmd,
    input  logic [ADDR_W-1:0] job_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ap_mode,
    output logic              ap_write_en,
    output logic              ap_sel_col,
    output logic [2:0]        ap_cmd,
    output logic [ADDR_W-1:0] ap_addr,
    output logic [DATA_W-1:0] ap_data,
    input  logic [DATA_W-1:0] ap_data_out,
    input  logic              ap_state_irq
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_A  = 3'd1;
    localparam logic [2:0] S_LOAD_B  = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_RD_ADDR = 3'd4;
    localparam logic [2:0] S_RD_WAIT = 3'd5;
    localparam logic [2:0] S_RD_OUT  = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    // The watchdog needs at least one RUN cycle to count.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] rows_q, rows_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              first_q, first_d;
    logic              last_row;

`ifdef AP_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign last_row = (row_q == rows_q);
    assign out_data = res_q;

    // Decode the AP control pins and host handshakes from the current state.
    always_comb begin
        job_ready   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        ap_mode     = 1'b0;
        ap_write_en = 1'b0;
        ap_sel_col  = 1'b0;
        ap_cmd      = 3'd0;
        ap_addr     = '0;
        ap_data     = '0;
        unique case (state_q)
            S_IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
            end
            S_LOAD_A: begin
                ap_write_en = in_valid;
                ap_addr     = row_q;
                ap_data     = in_a;
            end
            S_LOAD_B: begin
                ap_write_en = 1'b1;
                ap_sel_col  = 1'b1;
                ap_addr     = row_q;
                ap_data     = in_b;
                in_ready    = 1'b1;
            end
            S_RUN: begin
                ap_mode = 1'b1;
                ap_cmd  = cmd_q;
            end
            S_RD_ADDR, S_RD_WAIT: begin
                ap_addr    = row_q;
                ap_sel_col = RES_COL;
            end
            S_RD_OUT: begin
                out_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequence the job: load pairs, run, read back results row by row.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        rows_d  = rows_q;
        cmd_d   = cmd_q;
        res_d   = res_q;
        first_d = 1'b0;
`ifdef AP_CTRL_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    state_d = S_LOAD_A;
                    cmd_d   = job_cmd;
                    rows_d  = job_rows;
                    row_d   = '0;
`ifdef AP_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_LOAD_A: begin
                if (in_valid) begin
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (last_row) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    first_d = 1'b1;
                end else begin
                    state_d = S_LOAD_A;
                    row_d   = row_q + ADDR_W'(1);
                end
            end
            S_RUN: begin
                // An irq left over from before RUN is ignored on entry.
                if (ap_state_irq && !first_q) begin
                    state_d = S_RD_ADDR;
                end
`ifdef AP_CTRL_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
`endif
            end
            S_RD_ADDR: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                res_d   = ap_data_out;
                state_d = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (out_ready) begin
                    if (last_row) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_ADDR;
                        row_d   = row_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            rows_q  <= '0;
            cmd_q   <= 3'd0;
            res_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rows_q  <= rows_d;
            cmd_q   <= cmd_d;
            res_q   <= res_d;
            first_q <= first_d;
        end
    end

`ifdef AP_CTRL_TIMEOUT_EN
    // RUN watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_ap_job_ctrl.sv
// tb_ap_job_ctrl: directed bench for ap_job_ctrl with a small AP model.
// Timeout cases run only when AP_CTRL_TIMEOUT_EN is defined.
module tb_ap_job_ctrl;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [2:0]    job_cmd = 3'd0;
    logic [AW-1:0] job_rows = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          err;
    logic          ap_mode;
    logic          ap_write_en;
    logic          ap_sel_col;
    logic [2:0]    ap_cmd;
    logic [AW-1:0] ap_addr;
    logic [DW-1:0] ap_data;
    logic [DW-1:0] ap_data_out = '0;
    logic          ap_state_irq;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ap_job_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .RES_COL(1'b0),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_cmd(job_cmd),
        .job_rows(job_rows),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
        .done(done),
        .err(err),
        .ap_mode(ap_mode),
        .ap_write_en(ap_write_en),
        .ap_sel_col(ap_sel_col),
        .ap_cmd(ap_cmd),
        .ap_addr(ap_addr),
        .ap_data(ap_data),
        .ap_data_out(ap_data_out),
        .ap_state_irq(ap_state_irq)
    );

    // AP model and activity monitor.
    logic [DW-1:0]    col_a [0:(1<<AW)-1];
    logic [DW-1:0]    col_b [0:(1<<AW)-1];
    logic [AW+DW:0]   wr_q [$];
    int               wc_q [$];
    logic [DW-1:0]    res_q [$];
    int               cyc = 0;
    int               acc_cyc = 0;
    int               mode_cyc = 0;
    int               ov_cnt = 0;
    int               done_cnt = 0;
    int               run_cnt = 0;
    logic [2:0]       run_cmd = 3'd0;
    logic             irq_force = 1'b0;
    int               irq_at = 3;

    assign ap_state_irq = irq_force | (ap_mode & (run_cnt >= irq_at));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (job_valid && job_ready) acc_cyc <= cyc;
        if (ap_write_en) begin
            wr_q.push_back({ap_sel_col, ap_addr, ap_data});
            wc_q.push_back(cyc);
            if (ap_sel_col) col_b[ap_addr] <= ap_data;
            else col_a[ap_addr] <= ap_data;
        end
        if (ap_mode) begin
            mode_cyc <= mode_cyc + 1;
            run_cmd  <= ap_cmd;
        end
        run_cnt <= ap_mode ? run_cnt + 1 : 0;
        ap_data_out <= col_a[ap_addr] + col_b[ap_addr];
        if (out_valid && out_ready) res_q.push_back(out_data);
        if (out_valid) ov_cnt <= ov_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    logic [DW-1:0] pa [4];
    logic [DW-1:0] pb [4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [2:0] cmd, input logic [AW-1:0] rows);
        @(negedge clk);
        job_valid = 1'b1;
        job_cmd   = cmd;
        job_rows  = rows;
    endtask

    // Feed n pairs; with tog set, one idle cycle precedes every LOAD_A write.
    task automatic feed(input int n, input bit tog);
        int idx;
        int cnt;
        bit stall;
        idx = 0;
        cnt = 0;
        stall = tog;
        while (idx < n && cnt < 500) begin
            @(negedge clk);
            cnt++;
            job_valid = 1'b0;
            in_a = pa[idx];
            in_b = pb[idx];
            if (in_ready) begin
                in_valid = 1'b1;
                idx++;
                stall = tog;
            end else if (stall) begin
                in_valid = 1'b0;
                stall = 1'b0;
            end else begin
                in_valid = 1'b1;
            end
        end
        chk("feed_pairs", idx, n);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bp_row, input int bp_len,
                             input logic [DW-1:0] bp_exp, input int ob);
        int base;
        int cnt;
        int bp;
        base = done_cnt;
        cnt = 0;
        bp = 0;
        while (done_cnt == base && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            if (out_valid && (res_q.size() - ob) == bp_row && bp < bp_len) begin
                out_ready = 1'b0;
                bp++;
                chk("bp_valid", out_valid, 1);
                chk("bp_data", out_data, bp_exp);
            end else begin
                out_ready = 1'b1;
            end
        end
        out_ready = 1'b1;
        chk("done_seen", done_cnt - base, 1);
    endtask

    int wb, ob, mb, db, vb;
    logic [AW+DW:0] e;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_job_ready", job_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ap_mode", ap_mode, 0);
        chk("rst_ap_we", ap_write_en, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;

        // One-row job, irq in the 4th RUN cycle
        irq_force = 1'b0;
        irq_at = 3;
        pa[0] = 8'h05;
        pb[0] = 8'h03;
        wb = wr_q.size(); ob = res_q.size(); mb = mode_cyc; db = done_cnt;
        start_job(3'd5, '0);
        feed(1, 1'b0);
        chk("busy_during_job", busy, 1);
        chk("no_ready_busy", job_ready, 0);
        wait_done(-1, 0, 8'h00, ob);
        chk("r1_wr_cnt", wr_q.size() - wb, 2);
        chk("r1_wr0", wr_q[wb], {1'b0, 10'd0, 8'h05});
        chk("r1_wr1", wr_q[wb+1], {1'b1, 10'd0, 8'h03});
        chk("r1_wr_lat", wc_q[wb] - acc_cyc, 1);
        chk("r1_mode_cyc", mode_cyc - mb, 4);
        chk("r1_cmd", run_cmd, 3'd5);
        chk("r1_out_cnt", res_q.size() - ob, 1);
        chk("r1_out0", res_q[ob], 8'h08);
        @(negedge clk);
        chk("r1_done_pulse", done_cnt - db, 1);
        chk("r1_done_low", done, 0);
        chk("r1_idle", job_ready, 1);
        chk("r1_err", err, 0);

        // Four rows, stalled loads, irq pending before RUN, backpressure row 2
        pa[0] = 8'h10; pb[0] = 8'h01;
        pa[1] = 8'h20; pb[1] = 8'h02;
        pa[2] = 8'h30; pb[2] = 8'h03;
        pa[3] = 8'h40; pb[3] = 8'h04;
        irq_force = 1'b1;
        wb = wr_q.size(); ob = res_q.size(); mb = mode_cyc;
        start_job(3'd2, 10'd3);
        feed(4, 1'b1);
        wait_done(2, 10, 8'h33, ob);
        irq_force = 1'b0;
        chk("r4_wr_cnt", wr_q.size() - wb, 8);
        for (int k = 0; k < 8; k++) begin
            e = {k[0], AW'(k / 2), k[0] ? pb[k/2] : pa[k/2]};
            chk("r4_wr", wr_q[wb+k], e);
        end
        chk("r4_mode_cyc", mode_cyc - mb, 2);
        chk("r4_out_cnt", res_q.size() - ob, 4);
        for (int k = 0; k < 4; k++) begin
            chk("r4_out", res_q[ob+k], pa[k] + pb[k]);
        end

        // Reset in the middle of RUN, then a normal job
        irq_at = 1 << 30;
        pa[0] = 8'h11; pb[0] = 8'h22;
        start_job(3'd1, '0);
        feed(1, 1'b0);
        for (int k = 0; k < 50 && !ap_mode; k++) @(negedge clk);
        chk("mr_in_run", ap_mode, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_ap_mode", ap_mode, 0);
        chk("mr_ap_we", ap_write_en, 0);
        chk("mr_ready", job_ready, 1);
        chk("mr_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        irq_at = 2;
        pa[0] = 8'h7F; pb[0] = 8'h01;
        pa[1] = 8'h01; pb[1] = 8'hFF;
        ob = res_q.size(); mb = mode_cyc;
        start_job(3'd6, 10'd1);
        feed(2, 1'b0);
        wait_done(-1, 0, 8'h00, ob);
        chk("mr_mode_cyc", mode_cyc - mb, 3);
        chk("mr_out_cnt", res_q.size() - ob, 2);
        chk("mr_out0", res_q[ob], 8'h80);
        chk("mr_out1", res_q[ob+1], 8'h00);

`ifdef AP_CTRL_TIMEOUT_EN
        // Watchdog: irq never arrives
        irq_at = 1 << 30;
        pa[0] = 8'h01; pb[0] = 8'h01;
        ob = res_q.size(); mb = mode_cyc; vb = ov_cnt;
        start_job(3'd3, '0);
        feed(1, 1'b0);
        wait_done(-1, 0, 8'h00, ob);
        @(negedge clk);
        chk("to_mode_cyc", mode_cyc - mb, 16);
        chk("to_err", err, 1);
        chk("to_no_valid", ov_cnt - vb, 0);
        chk("to_no_out", res_q.size() - ob, 0);
        irq_at = 3;
        pa[0] = 8'h0A; pb[0] = 8'h0B;
        start_job(3'd3, '0);
        feed(1, 1'b0);
        chk("to_err_clr", err, 0);
        wait_done(-1, 0, 8'h00, ob);
        chk("to_out", res_q[ob], 8'h15);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ap_job_ctrl.md
# ap_job_ctrl

Job sequencer for the associative processor (`AP`). Accepts one job at a time from a host: operation code, row count and a stream of operand pairs. Loads the pairs into AP columns A/B, runs the AP in associative mode until it raises its completion interrupt, then streams the result column back out. Sits between the host/bus logic and the `AP` instance and is the only block that drives the AP's control pins.

## Interface
Parameters:
- `ADDR_W`, 10: AP row address width; max rows = 2**ADDR_W.
- `DATA_W`, 8: AP data width.
- `RES_COL`, 0: value driven on `ap_sel_col` when reading results.
- `TIMEOUT_CYCLES`, 4096: RUN watchdog limit; used only with `AP_CTRL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  host job request.
- `job_ready`  out  1  high only in IDLE.
- `job_cmd`  in  3  AP operation code, latched on accept.
- `job_rows`  in  ADDR_W  row count minus one (0 = 1 row, all-ones = 2**ADDR_W rows).
- `in_valid` / `in_ready`  in/out  1  operand-pair stream handshake.
- `in_a`, `in_b`  in  DATA_W  operand pair for current row.
- `out_valid` / `out_ready`  out/in  1  result stream handshake.
- `out_data`  out  DATA_W  result word, row order 0..N-1.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse on job completion.
- `err`  out  1  sticky timeout flag; cleared on next job accept.
- `ap_mode`, `ap_write_en`, `ap_sel_col`  out  1  AP controls.
- `ap_cmd`  out  3; `ap_addr`  out  ADDR_W; `ap_data`  out  DATA_W.
- `ap_data_out`  in  DATA_W; `ap_state_irq`  in  1.

## Operation
- States: IDLE, LOAD_A, LOAD_B, RUN, RD_ADDR, RD_WAIT, RD_OUT, DONE.
- IDLE: `job_ready`=1. Accept on `job_valid&&job_ready`: latch cmd/rows, row counter=0, clear `err`, go LOAD_A.
- LOAD_A: if `in_valid`: `ap_write_en`=1, `ap_sel_col`=0, `ap_addr`=row, `ap_data`=`in_a`; go LOAD_B. Else stall, `ap_write_en`=0.
- LOAD_B: `ap_write_en`=1, `ap_sel_col`=1, `ap_data`=`in_b`, `in_ready`=1 (pair consumed here). Last row -> RUN, row=0; else row+1 -> LOAD_A. `in_ready` is 0 in all other states.
- RUN: `ap_mode`=1, `ap_cmd`=latched cmd, `ap_write_en`=0. Exit when `ap_state_irq` sampled 1 in a RUN cycle other than the first -> RD_ADDR, `ap_mode` drops same edge.
- RD_ADDR: `ap_addr`=row, `ap_sel_col`=`RES_COL`, `ap_write_en`=0 -> RD_WAIT.
- RD_WAIT: capture `ap_data_out` into output register -> RD_OUT.
- RD_OUT: `out_valid`=1, `out_data` stable until `out_ready`. On handshake: last row -> DONE, else row+1 -> RD_ADDR.
- DONE: `done`=1 for one cycle -> IDLE.
- Row counter ADDR_W bits; last row = counter==latched `job_rows`; no wrap beyond it.
- New `job_valid` while busy ignored (no queuing).

## Timing
- Reset (asserted any time, incl. mid-job): state=IDLE immediately; all outputs 0 except `job_ready`=1; `err`=0; AP left with `ap_mode`=0, `ap_write_en`=0. Partial AP contents undefined.
- Accept at edge T: first AP write earliest at T+1.
- Load: 2 cycles per row with continuous `in_valid`; `in_valid` low in LOAD_A inserts stall cycles.
- `ap_mode` high for >=2 cycles per job.
- AP read latency 1 cycle; result word latency 3 cycles/row with `out_ready` held high.
- `out_ready` low holds RD_OUT indefinitely; no data loss.
- `ap_state_irq` already high on entry to RUN is ignored for that first cycle only.

## Configuration
- `AP_CTRL_TIMEOUT_EN` defined: RUN counts cycles; on reaching `TIMEOUT_CYCLES` without irq, drop `ap_mode`, set `err`=1, skip read phase, go DONE (`done` still pulses, no `out_valid`).
- Undefined: no counter, `err` tied 0, RUN waits forever.

## Test plan
- Reset: hold `rst`=0 -> `job_ready`=1, `busy`=0, `ap_mode`=0, `ap_write_en`=0, `done`=0.
- One-row job, `job_rows`=0, pair (0x05,0x03), irq after 4 cycles, AP model result 0x08 -> writes addr0 col0=0x05, col1=0x03; `ap_mode` 4+ cycles; one `out_data`=0x08; `done` pulse.
- Four rows, `in_valid` toggling 1/0 -> exactly 8 writes, addresses 0,0,1,1,2,2,3,3, no writes on stall cycles.
- Result backpressure: `out_ready` low 10 cycles on row 2 -> `out_data` stable, row order 0..3 preserved, no skipped row.
- Reset mid-RUN -> `ap_mode`=0 next edge-free; new job accepted afterwards and completes normally.
- `AP_CTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, irq never asserted -> `ap_mode` drops after 16 RUN cycles, `err`=1, `done` pulses, no `out_valid`; `err` clears on next accept.
